// File: rtl/cpu_pkg.sv
// Shared definitions for the phase responder: opcodes, phase bit positions,
// FSM states and the execute-beat table.
package cpu_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpJmp   = 4'h4;
  localparam logic [3:0] OpMul   = 4'h5;
  localparam logic [3:0] OpHalt  = 4'hF;

  // Bit positions within phase = {Mif, Mex, T1, T2, T3, T4}
  localparam int unsigned PhMif = 5;
  localparam int unsigned PhMex = 4;
  localparam int unsigned PhT1  = 3;
  localparam int unsigned PhT2  = 2;
  localparam int unsigned PhT3  = 1;
  localparam int unsigned PhT4  = 0;

  typedef enum logic [1:0] {S_WAIT, S_MEM, S_UOP, S_DONE} state_e;

  // Execute beats minus one for an opcode; unknown opcodes take a single beat.
  function automatic logic [1:0] op_beats(input logic [3:0] op);
    case (op)
      OpAdd:            op_beats = 2'd1;
      OpLoad, OpStore:  op_beats = 2'd2;
      OpMul:            op_beats = 2'd3;
      OpNop, OpJmp, OpHalt: op_beats = 2'd0;
      default:          op_beats = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/phase_responder_if.sv
// Memory-read and micro-op handshakes between the responder and its
// memory / datapath partners.
interface phase_responder_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          uop_valid;
  logic [5:0]    uop_code;
  logic          uop_ack;

  modport master (
    output mem_req, mem_addr, uop_valid, uop_code,
    input  mem_rdata, mem_ready, uop_ack
  );

  modport slave (
    input  mem_req, mem_addr, uop_valid, uop_code,
    output mem_rdata, mem_ready, uop_ack
  );
endinterface

// File: rtl/phase_decode.sv
// Classifies the current phase strobes: legality, new-beat detection and
// which beat (IF1, IF2, EX1..EX4) it is.
module phase_decode
  import cpu_pkg::*;
(
  input  logic [5:0] phase,
  input  logic [5:0] phase_q,
  output logic       beat_start,
  output logic       is_if1,
  output logic       is_if2,
  output logic [1:0] ex_idx,
  output logic       illegal
);
  logic [3:0] beats;
  logic       legal;

  assign beats = phase[PhT1:PhT4];
  // Fetch cycles only have two beats, so Mif with T3/T4 is malformed.
  assign legal = (phase[PhMif] ^ phase[PhMex]) && $onehot(beats) &&
                 !(phase[PhMif] && (phase[PhT3] || phase[PhT4]));

  assign illegal    = (|phase) && !legal;
  assign beat_start = legal && (phase != phase_q);
  assign is_if1     = beat_start && phase[PhMif] && phase[PhT1];
  assign is_if2     = beat_start && phase[PhMif] && phase[PhT2];

  always_comb begin
    ex_idx = 2'd0;
    if (phase[PhT2])      ex_idx = 2'd1;
    else if (phase[PhT3]) ex_idx = 2'd2;
    else if (phase[PhT4]) ex_idx = 2'd3;
  end
endmodule

// File: rtl/phase_responder.sv
// Responder side of the machine-cycle/beat handshake: owns PC and IR, fetches,
// decodes and issues one micro-op per execute beat, acknowledging each beat with done.
module phase_responder
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Mif,
  input  logic          Mex,
  input  logic          T1,
  input  logic          T2,
  input  logic          T3,
  input  logic          T4,
  output logic          done,
  output logic          stop,
  output logic [1:0]    cnt_set,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] pc,
  output logic          err,
  phase_responder_if.master bus
);
  state_e        state_q, state_d;
  logic [5:0]    phase, phase_q, phase_ref;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [5:0]    uop_code_q, uop_code_d;
  logic          stop_q, stop_d, err_q, err_d, restart_q, restart_d;
  logic          mem_req_q, mem_req_d, uop_valid_q, uop_valid_d;
  logic          beat_start, is_if1, is_if2, illegal, accept;
  logic [1:0]    ex_idx;
  logic [3:0]    opcode;

  assign phase  = {Mif, Mex, T1, T2, T3, T4};
  assign opcode = ir_q[DW-1:DW-4];
  // After an aborted beat the pending phase must still count as new.
  assign phase_ref = restart_q ? 6'b0 : phase_q;

  phase_decode u_phase_decode (
    .phase      (phase),
    .phase_q    (phase_ref),
    .beat_start (beat_start),
    .is_if1     (is_if1),
    .is_if2     (is_if2),
    .ex_idx     (ex_idx),
    .illegal    (illegal)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    stop_d      = stop_q;
    mem_req_d   = mem_req_q;
    uop_valid_d = uop_valid_q;
    uop_code_d  = uop_code_q;
    err_d       = err_q | illegal;
    restart_d   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_WAIT, S_DONE: begin
        state_d = S_WAIT;
        accept  = 1'b1;
      end
      S_MEM: begin
        if (phase != phase_q) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          restart_d = 1'b1;
          state_d   = S_WAIT;
        end else if (bus.mem_ready) begin
          ir_d      = bus.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_UOP: begin
        if (phase != phase_q) begin
          err_d       = 1'b1;
          uop_valid_d = 1'b0;
          restart_d   = 1'b1;
          state_d     = S_WAIT;
        end else if (bus.uop_ack) begin
          uop_valid_d = 1'b0;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          if (opcode == OpJmp && uop_code_q[1:0] == 2'd0) pc_d = ir_q[AW-1:0];
          state_d = S_DONE;
        end
      end
      default: state_d = S_WAIT;
    endcase

    if (accept && beat_start) begin
      if (is_if1) begin
        stop_d    = 1'b0;
        mem_req_d = 1'b1;
        state_d   = S_MEM;
      end else if (is_if2) begin
        pc_d    = pc_q + AW'(1);
        stop_d  = (opcode == OpHalt);
        cnt_d   = op_beats(opcode);
        state_d = S_DONE;
      end else begin
        uop_valid_d = 1'b1;
        uop_code_d  = {opcode, ex_idx};
        state_d     = S_UOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      phase_q     <= 6'b0;
      pc_q        <= '0;
      ir_q        <= '0;
      cnt_q       <= 2'd0;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      restart_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      uop_valid_q <= 1'b0;
      uop_code_q  <= 6'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      stop_q      <= stop_d;
      err_q       <= err_d;
      restart_q   <= restart_d;
      mem_req_q   <= mem_req_d;
      uop_valid_q <= uop_valid_d;
      uop_code_q  <= uop_code_d;
    end
  end

  assign done          = (state_q == S_DONE);
  assign stop          = stop_q;
  assign cnt_set       = cnt_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign err           = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = pc_q;
  assign bus.uop_valid = uop_valid_q;
  assign bus.uop_code  = uop_code_q;
endmodule

// File: tb/tb_phase_responder.sv
// Directed bench for phase_responder: an opcode table plus hand-written
// latency, wait-state and fault sequences.
module tb_phase_responder;
  localparam logic [5:0] P_IDLE = 6'b00_0000;
  localparam logic [5:0] P_IF1  = 6'b10_1000;
  localparam logic [5:0] P_IF2  = 6'b10_0100;

  logic        clk, rst_n, Mif, Mex, T1, T2, T3, T4;
  logic        done, stop, err;
  logic [1:0]  cnt_set;
  logic [15:0] ir;
  logic [11:0] pc;
  logic [15:0] mem [0:4095];
  int          mem_wait, ack_wait, mem_cnt, ack_cnt;
  logic        force_hs;
  int          checks, errors;

  phase_responder_if #(.AW(12), .DW(16)) bus ();

  phase_responder #(.AW(12), .DW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Mif     (Mif),
    .Mex     (Mex),
    .T1      (T1),
    .T2      (T2),
    .T3      (T3),
    .T4      (T4),
    .done    (done),
    .stop    (stop),
    .cnt_set (cnt_set),
    .ir      (ir),
    .pc      (pc),
    .err     (err),
    .bus     (bus)
  );

  // Memory and datapath partners with programmable response delay.
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = (bus.mem_req && mem_cnt >= mem_wait) || force_hs;
  assign bus.uop_ack   = (bus.uop_valid && ack_cnt >= ack_wait) || force_hs;

  always @(posedge clk) begin
    mem_cnt <= (bus.mem_req && !bus.mem_ready) ? mem_cnt + 1 : 0;
    ack_cnt <= (bus.uop_valid && !bus.uop_ack) ? ack_cnt + 1 : 0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    int          beats;
    logic        stop;
    logic [11:0] pc_after;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic set_phase(input logic [5:0] p);
    {Mif, Mex, T1, T2, T3, T4} = p;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [5:0] ex_ph(input int n);
    logic [5:0] t;
    t = 6'b00_1000;
    return 6'b01_0000 | (t >> n);
  endfunction

  task automatic do_reset();
    set_phase(P_IDLE);
    force_hs = 1'b0;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one beat and waits (bounded) for done; lat counts negedges to done.
  task automatic run_beat(input logic [5:0] p, output int lat, output int hs_at,
                          output int reqs, output logic stable);
    logic [5:0] code0;
    logic       have;
    set_phase(p);
    lat = 0; hs_at = -1; reqs = 0; stable = 1'b1; have = 1'b0; code0 = 6'b0;
    do begin
      tick();
      lat++;
      if (bus.mem_req) reqs++;
      if (hs_at < 0 && ((bus.mem_req && bus.mem_ready) || (bus.uop_valid && bus.uop_ack)))
        hs_at = lat;
      if (bus.uop_valid) begin
        if (!have) begin code0 = bus.uop_code; have = 1'b1; end
        else if (bus.uop_code !== code0) stable = 1'b0;
      end
    end while (!done && lat < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no done expected done for phase 'b%b", p);
    end
  endtask

  initial begin
    int lat, hs, rq, cnt;
    logic st;
    checks = 0; errors = 0;
    mem_wait = 0; ack_wait = 0; force_hs = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;

    vecs[0] = '{16'h0000, 1, 1'b0, 12'h001};
    vecs[1] = '{16'h3000, 2, 1'b0, 12'h001};
    vecs[2] = '{16'h1ABC, 3, 1'b0, 12'h001};
    vecs[3] = '{16'h2ABC, 3, 1'b0, 12'h001};
    vecs[4] = '{16'h5000, 4, 1'b0, 12'h001};
    vecs[5] = '{16'h7000, 1, 1'b0, 12'h001};
    vecs[6] = '{16'hC123, 1, 1'b0, 12'h001};
    vecs[7] = '{16'hF000, 0, 1'b1, 12'h001};
    vecs[8] = '{16'h4123, 1, 1'b0, 12'h123};

    // Reset state
    do_reset();
    check("rst_done", done, 0);
    check("rst_stop", stop, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_uop_valid", bus.uop_valid, 0);
    check("rst_err", err, 0);
    check("rst_cnt_set", cnt_set, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_uop_code", bus.uop_code, 0);

    // ADD with exact best-case latency
    mem[0] = 16'h3000;
    set_phase(P_IF1);
    tick();
    check("add_if1_req", bus.mem_req, 1);
    check("add_if1_addr", bus.mem_addr, 0);
    check("add_if1_nodone", done, 0);
    tick();
    check("add_if1_done", done, 1);
    check("add_ir", ir, 16'h3000);
    set_phase(P_IF2);
    tick();
    check("add_if2_done", done, 1);
    check("add_pc", pc, 1);
    check("add_cnt", cnt_set, 1);
    check("add_stop", stop, 0);
    set_phase(ex_ph(0));
    tick();
    check("add_ex1_code", bus.uop_code, 6'b0011_00);
    check("add_ex1_valid", bus.uop_valid, 1);
    tick();
    check("add_ex1_done", done, 1);
    check("add_ex1_cnt", cnt_set, 0);
    set_phase(ex_ph(1));
    tick();
    check("add_ex2_code", bus.uop_code, 6'b0011_01);
    tick();
    check("add_ex2_done", done, 1);

    // Opcode table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      mem[0] = vecs[i].instr;
      run_beat(P_IF1, lat, hs, rq, st);
      check("tbl_if1_lat", lat, 2);
      check("tbl_ir", ir, vecs[i].instr);
      run_beat(P_IF2, lat, hs, rq, st);
      check("tbl_if2_lat", lat, 1);
      check("tbl_stop", stop, vecs[i].stop);
      check("tbl_cnt", cnt_set, (vecs[i].beats == 0) ? 0 : vecs[i].beats - 1);
      for (int b = 0; b < vecs[i].beats; b++) begin
        run_beat(ex_ph(b), lat, hs, rq, st);
        check("tbl_ex_lat", lat, 2);
        check("tbl_ex_code", bus.uop_code, {vecs[i].instr[15:12], 2'(b)});
        check("tbl_ex_cnt", cnt_set, (vecs[i].beats - 2 - b > 0) ? vecs[i].beats - 2 - b : 0);
      end
      set_phase(P_IDLE);
      tick();
      check("tbl_pc", pc, vecs[i].pc_after);
      if (vecs[i].stop) begin
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (done || bus.mem_req || bus.uop_valid) cnt++;
        end
        check("halt_quiet", cnt, 0);
        check("halt_stop_hold", stop, 1);
      end
    end

    // MUL with three-clock acknowledge delay
    do_reset();
    mem[0] = 16'h5000;
    ack_wait = 3;
    run_beat(P_IF1, lat, hs, rq, st);
    run_beat(P_IF2, lat, hs, rq, st);
    check("mul_cnt0", cnt_set, 3);
    for (int b = 0; b < 4; b++) begin
      run_beat(ex_ph(b), lat, hs, rq, st);
      check("mul_lat", lat, 5);
      check("mul_done_after_ack", lat - hs, 1);
      check("mul_code_stable", st, 1);
      check("mul_code", bus.uop_code, {4'h5, 2'(b)});
      check("mul_cnt", cnt_set, (b < 3) ? 2 - b : 0);
    end
    ack_wait = 0;

    // JMP target and PC wrap
    do_reset();
    mem[0] = 16'h4123;
    run_beat(P_IF1, lat, hs, rq, st);
    run_beat(P_IF2, lat, hs, rq, st);
    run_beat(ex_ph(0), lat, hs, rq, st);
    check("jmp_pc", pc, 12'h123);
    set_phase(P_IF1);
    tick();
    check("jmp_fetch_addr", bus.mem_addr, 12'h123);
    do_reset();
    mem[0]     = 16'h4FFF;
    mem[12'hFFF] = 16'h0000;
    run_beat(P_IF1, lat, hs, rq, st);
    run_beat(P_IF2, lat, hs, rq, st);
    run_beat(ex_ph(0), lat, hs, rq, st);
    check("wrap_pre_pc", pc, 12'hFFF);
    run_beat(P_IF1, lat, hs, rq, st);
    run_beat(P_IF2, lat, hs, rq, st);
    check("wrap_pc", pc, 0);

    // Memory wait states
    do_reset();
    mem[0] = 16'h1234;
    mem_wait = 5;
    set_phase(P_IF1);
    rq = 0; cnt = 0; hs = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (bus.mem_req) rq++;
      if (done) cnt++;
      if (k < 7 && ir !== 16'h0000) hs++;
    end
    check("ws_req_cycles", rq, 6);
    check("ws_done_at_7", done, 1);
    check("ws_single_done", cnt, 1);
    check("ws_ir_early", hs, 0);
    check("ws_ir", ir, 16'h1234);
    cnt = 0;
    repeat (3) begin tick(); if (done) cnt++; end
    check("ws_no_redone", cnt, 0);
    mem_wait = 0;

    // Spurious handshakes while idle are ignored
    do_reset();
    force_hs = 1'b1;
    cnt = 0;
    repeat (3) begin tick(); if (done) cnt++; end
    force_hs = 1'b0;
    check("spurious_done", cnt, 0);
    check("spurious_ir", ir, 0);

    // Illegal phases
    do_reset();
    set_phase(6'b11_1000);
    cnt = 0;
    repeat (5) begin tick(); if (done || bus.mem_req) cnt++; end
    check("illegal_both_err", err, 1);
    check("illegal_both_quiet", cnt, 0);
    set_phase(P_IDLE);
    repeat (2) tick();
    check("err_sticky", err, 1);
    do_reset();
    set_phase(6'b10_0010);
    repeat (2) tick();
    check("illegal_mif_t3_err", err, 1);

    // Phase change while a micro-op is outstanding
    do_reset();
    ack_wait = 1000;
    set_phase(ex_ph(0));
    tick();
    check("abort_uop_valid", bus.uop_valid, 1);
    set_phase(ex_ph(1));
    tick();
    check("abort_err", err, 1);
    check("abort_drop", bus.uop_valid, 0);
    tick();
    check("abort_restart_valid", bus.uop_valid, 1);
    check("abort_restart_code", bus.uop_code, 6'b0000_01);
    ack_wait = 0;

    // Reset during an outstanding fetch
    do_reset();
    mem[0] = 16'h5000;
    run_beat(P_IF1, lat, hs, rq, st);
    run_beat(P_IF2, lat, hs, rq, st);
    mem_wait = 1000;
    set_phase(P_IF1);
    tick();
    check("rmem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    tick();
    check("rmem_req_clr", bus.mem_req, 0);
    check("rmem_pc", pc, 0);
    check("rmem_ir", ir, 0);
    check("rmem_cnt", cnt_set, 0);
    check("rmem_done", done, 0);
    check("rmem_err", err, 0);
    set_phase(P_IDLE);
    rst_n = 1'b1;
    mem_wait = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_responder.md
Name: phase_responder

Overview:
- Responder side of the machine-cycle/beat handshake. Consumes the phase strobes Mif, Mex and T1..T4 from the timing generator. Returns done, stop and cnt_set.
- Owns the PC and IR. Performs the instruction fetch (IF1), the decode (IF2), and issues one micro-op per execute beat (EX1..EX4) to the datapath over a valid/ack handshake.

Parameters:
- AW, 12, PC / memory address width.
- DW, 16, instruction / memory data width; opcode is ir[DW-1:DW-4].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- Mif  in  1  fetch machine cycle active
- Mex  in  1  execute machine cycle active
- T1, T2, T3, T4  in  1 each  beat strobes, one-hot within a cycle
- done  out  1  one-clk pulse: current beat complete
- stop  out  1  decoded HALT; valid while done is high in IF2
- cnt_set  out  2  execute beats remaining after the current one; valid while done is high
- mem_req  out  1  instruction read request
- mem_addr  out  AW  read address (= pc)
- mem_rdata  in  DW  read data
- mem_ready  in  1  read data valid this clk
- uop_valid  out  1  micro-op offered
- uop_code  out  6  {opcode[3:0], beat_idx[1:0]}; beat_idx 0..3 = EX1..EX4
- uop_ack  in  1  datapath accepted/completed the micro-op
- ir  out  DW  instruction register
- pc  out  AW  program counter
- err  out  1  sticky illegal-phase flag

Behaviour:
- Reset: done=stop=mem_req=uop_valid=err=0, cnt_set=0, pc=0, ir=0, uop_code=0, FSM=S_WAIT, phase_q=0.
- phase = {Mif,Mex,T1,T2,T3,T4}, registered each clk into phase_q. Beat start = (phase != phase_q) && phase != 0 && phase legal.
- Legal phase: exactly one of Mif/Mex, and exactly one of T1..T4; Mif is legal only with T1/T2. An illegal nonzero phase sets err (sticky until reset) and starts no work.
- All-zero phase (generator idle) starts no work. stop and cnt_set hold their values.
- FSM states: S_WAIT, S_MEM, S_UOP, S_DONE.
- S_WAIT, on beat start:
  - IF1: clear stop; go to S_MEM; mem_req=1, mem_addr=pc.
  - IF2: decode ir; pc<=pc+1; set stop and cnt_set from the decode table; go to S_DONE.
  - EXn: uop_valid=1, uop_code={opcode, n-1}; go to S_UOP.
- S_MEM: hold mem_req until mem_ready. On mem_ready: ir<=mem_rdata, mem_req<=0, go to S_DONE. No timeout.
- S_UOP: hold uop_valid/uop_code stable until uop_ack. On ack: uop_valid<=0; cnt_set<=cnt_set-1 if nonzero, else hold 0; go to S_DONE.
- S_DONE: done=1 for exactly one clk, then S_WAIT. The next beat is recognised only on a phase change, so done can never fire twice for one beat.
- Latency, best case (ready/ack in the first clk):
  - Beat visible at clk n; request/uop high at n+1; done at n+2; next phase visible at n+3.
  - IF2: done at n+1.
- Decode table (execute beats total; cnt_set = beats-1):
  - NOP 4'h0: 1 beat.
  - JMP 4'h4: 1 beat; pc<=ir[AW-1:0] on the EX1 ack.
  - ADD 4'h3: 2 beats.
  - LOAD 4'h1: 3 beats.
  - STORE 4'h2: 3 beats.
  - MUL 4'h5: 4 beats.
  - HALT 4'hF: stop=1, cnt_set=0.
  - Any other opcode: 1 beat.
- pc wraps modulo 2^AW.
- uop_ack while uop_valid=0 is ignored. mem_ready outside S_MEM is ignored.
- A phase change while in S_MEM/S_UOP (protocol violation): sets err, drops the request, returns to S_WAIT, then treats the new phase as a beat start.
- rst_n low at any time: immediate return to reset values; any in-flight request is abandoned.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams.
  - phase index constants.
  - beat-count table function op_beats(opcode) returning 2-bit beats-1.
  - FSM state enum.
- One natural sub-module: phase_decode (combinational). Takes phase and phase_q; produces beat_start, is_if1, is_if2, ex_idx, illegal.

Test Plan:
- ADD fetch: mem[0]=16'h3000, mem_ready same clk.
  - IF1: mem_req at n+1, done at n+2, ir=16'h3000.
  - IF2: done, pc=1, cnt_set=1, stop=0.
  - EX1 uop_code=6'b0011_00, cnt_set=0 at its done; EX2 uop_code=6'b0011_01.
- HALT: mem[0]=16'hF000. IF2 done with stop=1, cnt_set=0; phase goes to 0; no further done, mem_req or uop_valid for 20 clk.
- MUL with 3-clk uop_ack delay per beat:
  - Four uops with beat_idx 0..3; each done exactly 1 clk after its ack.
  - cnt_set 3→2→1→0; uop_code stable while waiting.
- JMP: mem[0]=16'h4123. After EX1 ack, pc=12'h123; next IF1 mem_addr=12'h123. Separately, pc=12'hFFF with IF2 → pc=0.
- Wait states: mem_ready delayed 5 clk in IF1. mem_req stays high 6 clk; single done; ir latched only on the ready clk.
- Faults:
  - Mif=Mex=1 with T1 → err=1, no done.
  - Phase changes while in S_UOP → err=1, uop_valid drops.
  - rst_n low mid-S_MEM → all outputs at reset values next clk.
